// File: rtl/iter_integer_linear_inv_pkg.sv
// Shared constants and FSM encoding for the iterative linear inverse block.
package iter_integer_linear_inv_pkg;

    localparam int unsigned DEFAULT_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/iter_integer_linear_inv_if.sv
// Request/result bundle between a consumer (master) and the inverse evaluator (slave).
interface iter_integer_linear_inv_if
    import iter_integer_linear_inv_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) ();

    logic         wr;
    logic [W-1:0] m;
    logic [W-1:0] y;
    logic [W-1:0] b;
    logic [W-1:0] x;
    logic [W-1:0] r;
    logic         dz;
    logic         uf;
    logic         busy;
    logic         valid;

    modport master (
        output wr, m, y, b,
        input  x, r, dz, uf, busy, valid
    );

    modport slave (
        input  wr, m, y, b,
        output x, r, dz, uf, busy, valid
    );

endinterface

// File: rtl/iter_integer_linear_inv_udiv.sv
// W-cycle restoring unsigned divider, one quotient bit per cycle, MSB first.
module iter_udiv #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         done
);

    localparam int unsigned CW = $clog2(W);

    logic [W-1:0]  rem_q, quo_q, dvd_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic [W:0]    trial;
    logic          ge;
    logic [W-1:0]  rem_n, quo_n;

    always_comb begin
        trial = {rem_q, dvd_q[W-1]};
        ge    = trial >= {1'b0, divisor};
        // The true difference is below divisor, so W-bit wrap-around arithmetic is exact.
        rem_n = ge ? (trial[W-1:0] - divisor) : trial[W-1:0];
        quo_n = {quo_q[W-2:0], ge};
    end

    // Outputs present the result of the current step so the caller can latch it on the last edge.
    assign quotient  = quo_n;
    assign remainder = rem_n;
    assign done      = run_q && (cnt_q == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= '0;
            dvd_q <= dividend;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            dvd_q <= {dvd_q[W-2:0], 1'b0};
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iter_integer_linear_inv.sv
// Solves x = floor((y - b) / m) and r = (y - b) mod m with an iterative unsigned divider.
module iter_integer_linear_inv
    import iter_integer_linear_inv_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input logic                      clk,
    input logic                      rst,
    iter_integer_linear_inv_if.slave bus
);

    state_e       state;
    logic [W-1:0] m_l, y_l, b_l;
    logic [W-1:0] x_q, r_q;
    logic         dz_q, uf_q, done_q;

    logic         in_diff;
    logic         is_uf, is_dz;
    logic [W-1:0] diff;
    logic         div_start, div_done;
    logic [W-1:0] div_quo, div_rem;

    always_comb begin
        in_diff   = (bus.m != m_l) || (bus.y != y_l) || (bus.b != b_l);
        is_uf     = y_l < b_l;
        is_dz     = m_l == '0;
        diff      = y_l - b_l;
        div_start = (state == S_PREP) && !is_uf && !is_dz;
    end

    iter_udiv #(.W(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (diff),
        .divisor   (m_l),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            m_l    <= '0;
            y_l    <= '0;
            b_l    <= '0;
            x_q    <= '0;
            r_q    <= '0;
            dz_q   <= 1'b0;
            uf_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.wr && (!done_q || in_diff)) begin
                        m_l    <= bus.m;
                        y_l    <= bus.y;
                        b_l    <= bus.b;
                        done_q <= 1'b0;
                        state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    // Underflow takes priority over divide-by-zero.
                    if (is_uf) begin
                        x_q    <= '0;
                        r_q    <= '0;
                        uf_q   <= 1'b1;
                        dz_q   <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end else if (is_dz) begin
                        x_q    <= '1;
                        r_q    <= diff;
                        uf_q   <= 1'b0;
                        dz_q   <= 1'b1;
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        uf_q  <= 1'b0;
                        dz_q  <= 1'b0;
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (div_done) begin
                        x_q    <= div_quo;
                        r_q    <= div_rem;
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.x     = x_q;
    assign bus.r     = r_q;
    assign bus.dz    = dz_q;
    assign bus.uf    = uf_q;
    assign bus.busy  = state != S_IDLE;
    assign bus.valid = (state == S_IDLE) && done_q && !in_diff;

endmodule

// File: tb/tb_iter_integer_linear_inv.sv
// Directed bench with a result scoreboard checked by an independent monitor.
module tb_iter_integer_linear_inv;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] r;
        logic         dz;
        logic         uf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iter_integer_linear_inv_if #(.W(W)) bus ();

    iter_integer_linear_inv #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    res_t exp_q[$];
    res_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_valid = 1'b0;
    int   n;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: each rising valid consumes one expected result.
    always begin
        @(posedge clk);
        #2;
        if (bus.valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got x=%0h r=%0h, expected no result", bus.x, bus.r);
            end else begin
                mon_e = exp_q.pop_front();
                check("x", bus.x, mon_e.x);
                check("r", bus.r, mon_e.r);
                check("dz", W'(bus.dz), W'(mon_e.dz));
                check("uf", W'(bus.uf), W'(mon_e.uf));
            end
        end
        prev_valid = bus.valid;
    end

    task automatic run(input logic [W-1:0] mm, input logic [W-1:0] yy, input logic [W-1:0] bb,
                       input logic [W-1:0] xx, input logic [W-1:0] rr, input logic dzz,
                       input logic ufz, input int lat, input string name);
        int k;
        exp_q.push_back('{x: xx, r: rr, dz: dzz, uf: ufz});
        @(negedge clk);
        bus.m  = mm;
        bus.y  = yy;
        bus.b  = bb;
        bus.wr = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) begin
                bus.wr = 1'b0;
                check({name, "_busy"}, W'(bus.busy), W'(1));
            end
        end while (!bus.valid && k < 200);
        check({name, "_latency"}, W'(k), W'(lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr = 1'b0;
        bus.m  = '0;
        bus.y  = '0;
        bus.b  = '0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_x", bus.x, '0);
        check("rst_r", bus.r, '0);
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_valid", W'(bus.valid), W'(0));
        @(negedge clk);
        rst = 1'b0;

        run(32'd7, 32'd100, 32'd2, 32'd14, 32'd0, 1'b0, 1'b0, 34, "t1");
        run(32'd7, 32'd101, 32'd2, 32'd14, 32'd1, 1'b0, 1'b0, 34, "t2");

        // Same inputs after completion: must not restart.
        @(negedge clk);
        bus.wr = 1'b1;
        @(posedge clk);
        #1;
        check("t2_rewr_busy", W'(bus.busy), W'(0));
        check("t2_rewr_valid", W'(bus.valid), W'(1));
        bus.wr = 1'b0;

        run(32'd0, 32'd50, 32'd10, 32'hFFFF_FFFF, 32'd40, 1'b1, 1'b0, 2, "t3_dz");
        run(32'd3, 32'd5, 32'd10, 32'd0, 32'd0, 1'b0, 1'b1, 2, "t3_uf");
        run(32'd1, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 34, "t4_m1");
        run(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 34, "t4_big");
        run(32'd5, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 34, "t4_yeqb");

        // wr held high while y changes mid-calculation.
        exp_q.push_back('{x: 32'd10, r: 32'd1, dz: 1'b0, uf: 1'b0});
        @(negedge clk);
        bus.m  = 32'd3;
        bus.y  = 32'd30;
        bus.b  = 32'd0;
        bus.wr = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 34) begin
                check("t5_first_x", bus.x, 32'd10);
                check("t5_first_r", bus.r, 32'd0);
                check("t5_first_valid", W'(bus.valid), W'(0));
                check("t5_first_busy", W'(bus.busy), W'(0));
            end
            if (n == 10) begin
                @(negedge clk);
                bus.y = 32'd31;
            end
        end while (!bus.valid && n < 200);
        check("t5_latency", W'(n), W'(68));
        bus.wr = 1'b0;

        // Reset mid-calculation.
        @(negedge clk);
        bus.m  = 32'd7;
        bus.y  = 32'd100;
        bus.b  = 32'd2;
        bus.wr = 1'b1;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_busy", W'(bus.busy), W'(0));
        check("t6_valid", W'(bus.valid), W'(0));
        check("t6_x", bus.x, '0);
        check("t6_r", bus.r, '0);
        @(negedge clk);
        rst = 1'b0;
        run(32'd7, 32'd103, 32'd2, 32'd14, 32'd3, 1'b0, 1'b0, 34, "t6_fresh");

        repeat (3) @(posedge clk);
        #3;
        check("queue_drained", W'(exp_q.size()), W'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
